// File: rtl/riscv_soc_monitor.sv
// End-of-test monitor: snoops fetch/data buses, decides pass/fail/timeout/hang, captures signature words.
// Latency: bus events sampled at the rising edge, visible the next cycle; sig_rd_data is combinational.
// Backpressure: none -- purely passive observer, never stalls or drives the snooped buses.
module riscv_soc_monitor #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = 'h100,
  parameter logic [DATA_W-1:0] PASS_VALUE  = 1,
  parameter logic [ADDR_W-1:0] SIG_BASE    = 'h200,
  parameter int                SIG_DEPTH   = 16,
  parameter int                TIMEOUT     = 100000,
  parameter int                HANG_LIMIT  = 64,
  localparam int               IDX_W       = $clog2(SIG_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              inst_ce,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic              data_ce,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  input  logic [IDX_W-1:0]  sig_rd_idx,
  output logic [DATA_W-1:0] sig_rd_data,
  output logic [IDX_W:0]    sig_count,
  output logic [2:0]        state,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic              hang,
  output logic [DATA_W-1:0] result,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       fetch_cnt
);

  localparam int                HC_W     = $clog2(HANG_LIMIT + 1);
  localparam logic [31:0]       TO_LAST  = 32'(TIMEOUT - 1);
  localparam logic [HC_W-1:0]   HC_LAST  = HC_W'(HANG_LIMIT - 1);
  localparam logic [ADDR_W-1:0] SIG_SPAN = ADDR_W'(4 * SIG_DEPTH);
  localparam logic [IDX_W:0]    SIG_FULL = (IDX_W + 1)'(SIG_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4,
    S_HANG    = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic                done_d, pass_d, fail_d, timeout_d, hang_d;
  logic [ADDR_W-1:0]   prev_pc;
  logic                prev_valid;
  logic [HC_W-1:0]     hang_cnt;
  logic [DATA_W-1:0]   sig_mem [SIG_DEPTH];
  logic [ADDR_W-1:0]   sig_off;
  logic                run, tohost_hit, timeout_hit, same_fetch, hang_hit, sig_wr;

  assign run         = (state_q == S_RUN);
  assign tohost_hit  = data_ce & data_we & (data_addr == TOHOST_ADDR) & (data_wdata != '0);
  assign timeout_hit = (cycle_cnt == TO_LAST);
  assign same_fetch  = inst_ce & prev_valid & (inst_addr == prev_pc);
  assign hang_hit    = same_fetch & (hang_cnt == HC_LAST);

  // Unsigned wrap makes addresses below SIG_BASE fall out of range too.
  assign sig_off     = data_addr - SIG_BASE;
  assign sig_wr      = run & data_ce & data_we & (sig_off < SIG_SPAN) & (sig_off[1:0] == 2'b00);

  assign state       = state_q;
  assign sig_rd_data = sig_mem[sig_rd_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      done    <= 1'b0;
      pass    <= 1'b0;
      fail    <= 1'b0;
      timeout <= 1'b0;
      hang    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
      pass    <= pass_d;
      fail    <= fail_d;
      timeout <= timeout_d;
      hang    <= hang_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (enable) state_d = S_RUN;
      S_RUN: begin
        if (tohost_hit)       state_d = (data_wdata == PASS_VALUE) ? S_PASS : S_FAIL;
        else if (timeout_hit) state_d = S_TIMEOUT;
        else if (hang_hit)    state_d = S_HANG;
      end
      default: state_d = state_q;
    endcase
  end

  // Flags are decoded from the next state and registered so they never glitch.
  always_comb begin
    pass_d    = (state_d == S_PASS);
    fail_d    = (state_d == S_FAIL);
    timeout_d = (state_d == S_TIMEOUT);
    hang_d    = (state_d == S_HANG);
    done_d    = pass_d | fail_d | timeout_d | hang_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt  <= '0;
      fetch_cnt  <= '0;
      result     <= '0;
      prev_pc    <= '0;
      prev_valid <= 1'b0;
      hang_cnt   <= '0;
      sig_count  <= '0;
    end else if (run) begin
      if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 32'd1;
      if (inst_ce) begin
        if (fetch_cnt != '1) fetch_cnt <= fetch_cnt + 32'd1;
        prev_pc    <= inst_addr;
        prev_valid <= 1'b1;
      end
      hang_cnt <= same_fetch ? hang_cnt + HC_W'(1) : '0;
      if (tohost_hit) result <= data_wdata;
      if (sig_wr && sig_count != SIG_FULL) sig_count <= sig_count + (IDX_W + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SIG_DEPTH; i++) sig_mem[i] <= '0;
    end else if (sig_wr) begin
      sig_mem[sig_off[IDX_W+1:2]] <= data_wdata;
    end
  end

endmodule

// File: doc/riscv_soc_monitor.md
# riscv_soc_monitor

- Parametrised, synthesizable end-of-test monitor for the RISC-V SoC.
- Passively snoops the core's instruction-fetch and data-memory buses; it never drives them.
- Decides pass, fail, timeout or hang from program writes to a `tohost` address, a cycle budget and PC-stall detection.
- Captures a signature region into an internal buffer for readback. It replaces the single hard-wired `verify` word.
- Sits beside `riscv`, `inst_mem` and `data_mem` at SoC level, in simulation or on FPGA.

## Interface
Parameters:
- ADDR_W, 32: bus address width.
- DATA_W, 32: bus data width.
- TOHOST_ADDR, 32'h0000_0100: end-of-test write address.
- PASS_VALUE, 1: `tohost` value meaning pass. Any other nonzero value means fail.
- SIG_BASE, 32'h0000_0200: word-aligned base of the signature region.
- SIG_DEPTH, 16: number of signature words. Power of two, 2..256.
- TIMEOUT, 100000: maximum number of RUN cycles, ≥2.
- HANG_LIMIT, 64: consecutive same-PC fetches that count as a hang, ≥2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  start request, sampled only in IDLE.
- inst_ce  in  1  instruction fetch enable.
- inst_addr  in  ADDR_W  fetch address.
- data_ce  in  1  data access enable.
- data_we  in  1  data write enable.
- data_addr  in  ADDR_W  data address.
- data_wdata  in  DATA_W  write data.
- sig_rd_idx  in  log2(SIG_DEPTH)  signature read index.
- sig_rd_data  out  DATA_W  combinational read of signature word sig_rd_idx.
- sig_count  out  log2(SIG_DEPTH)+1  accepted signature writes, saturating at SIG_DEPTH.
- state  out  3  current state.
- done  out  1  high in any terminal state.
- pass  out  1  state is PASS.
- fail  out  1  state is FAIL.
- timeout  out  1  state is TIMEOUT.
- hang  out  1  state is HANG.
- result  out  DATA_W  value of the accepted `tohost` write.
- cycle_cnt  out  32  RUN cycles, saturating.
- fetch_cnt  out  32  RUN cycles with inst_ce=1, saturating.

## Operation
State encodings:
- IDLE=0, RUN=1, PASS=2, FAIL=3, TIMEOUT=4, HANG=5.
- Terminal states (2..5) are sticky until rst.

Transitions:
- IDLE→RUN at an edge where enable=1. enable is ignored in all other states.
- In RUN, the first matching event at an edge wins, in this priority order:
  1. `tohost` write: data_ce & data_we & data_addr==TOHOST_ADDR & data_wdata≠0.
     - data_wdata==PASS_VALUE → PASS, otherwise → FAIL.
     - result is loaded with data_wdata.
     - Zero-valued `tohost` writes are ignored.
  2. Timeout: cycle_cnt==TIMEOUT-1 → TIMEOUT.
  3. Hang: hang counter reaches HANG_LIMIT → HANG.

Hang detection:
- prev_pc and prev_valid are registered on every RUN edge with inst_ce=1.
- A fetch is "same" when inst_ce=1, prev_valid=1 and inst_addr==prev_pc.
- A same fetch increments the hang counter. Any other RUN cycle clears it to 0.
- The counter includes the first repeat, so HANG_LIMIT same-fetches trigger HANG.

Signature capture:
- Active only in RUN.
- Accepted write: data_ce & data_we, data_addr in [SIG_BASE, SIG_BASE+4·SIG_DEPTH), and data_addr[1:0]==0.
- Slot index is (data_addr−SIG_BASE)>>2. Rewriting a slot overwrites it.
- Each accepted write increments sig_count. Misaligned or out-of-range writes are ignored.
- A `tohost` write that falls inside the region is captured as well.

Counters:
- cycle_cnt increments on every RUN edge, including the edge that enters a terminal state.
- fetch_cnt increments on every RUN edge with inst_ce=1.
- Both freeze in terminal states and saturate at 2^32−1.

Flag decoding:
- done, pass, fail, timeout and hang are decoded from the state register and are glitch-free registered decodes.

## Timing
Reset:
- rst=0 immediately forces state=IDLE.
- The following outputs and internal registers all clear to 0: every flag, result, cycle_cnt, fetch_cnt, sig_count, all signature words, prev_valid and the hang counter.
- Reset in the middle of RUN aborts the test with no terminal flag.

Latency:
- Bus events are sampled at the rising edge. Their effect is visible one edge later, i.e. in the next cycle.
- sig_rd_data has zero latency from sig_rd_idx and reflects writes from the previous edge.

Simultaneous events:
- `tohost` write on the timeout edge → PASS or FAIL, not TIMEOUT.
- Timeout and hang on the same edge → TIMEOUT.
- A signature write and a `tohost` write on the same edge (different addresses cannot coincide on one bus) is not possible; only one data access exists per cycle.

## Test plan
- Reset: assert rst=0 mid-RUN with cycle_cnt=37 → state=0 and all outputs 0 before the next edge. Release, enable → RUN.
- Pass: enable, then in the 10th RUN cycle write 1 to 0x100 → next cycle pass=1, done=1, result=1, cycle_cnt=10. Further writes change nothing.
- Fail: write 0 to 0x100 → ignored, still RUN. Then write 0x2A → fail=1, result=42.
- Signature: write 0xA to 0x200, 0xB to 0x204, 0xC to 0x23C, 0xD to 0x202, 0xE to 0x240 → idx0=0xA, idx1=0xB, idx15=0xC, sig_count=3.
- Timeout with TIMEOUT=50, no `tohost` → timeout=1 and cycle_cnt=50 frozen. Rerun with a PASS write on RUN cycle 50 → pass=1, timeout=0.
- Hang with HANG_LIMIT=8: hold inst_addr=0x40 with inst_ce=1 → hang after the 8th repeat. Changing the address after 7 repeats restarts the count, and no hang is flagged until 8 new repeats occur.
